// File: rtl/sdc_cnt_pkg.sv
// Shared types and default sizes for the SD-card data-path counters.
// Default terminal counts for the block/word/CRC framing counters.
package sdc_cnt_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } seq_state_e;

    localparam int unsigned WordCntDw   = 8;
    localparam logic [7:0]  WordCntMax  = 8'h40;
    localparam int unsigned WordBitsDw  = 6;
    localparam logic [5:0]  WordBitsMax = 6'h3F;
    localparam int unsigned CrcBitsDw   = 5;
    localparam logic [4:0]  CrcBitsMax  = 5'h10;

endpackage

// File: rtl/counter_seq.sv
// One-shot sequence counter: armed by start_strb_i, counts enabled clocks up to SEQ_MAX,
// then pulses strb_o once and returns to idle.
module counter_seq
    import sdc_cnt_pkg::*;
#(
    parameter int unsigned       SEQ_DW  = WordBitsDw,
    parameter logic [SEQ_DW-1:0] SEQ_MAX = WordBitsMax
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              start_strb_i,
    output logic [SEQ_DW-1:0] value_o,
    output logic              busy_o,
    output logic              strb_o
);

    seq_state_e        state_q, state_d;
    logic [SEQ_DW-1:0] value_q, value_d;
    logic              strb_q, strb_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            value_q <= '0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        strb_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_strb_i) begin
                    state_d = StRun;
                    value_d = '0;
                end
            end
            StRun: begin
                // A start strobe wins over the terminal count, so no strobe on restart.
                if (start_strb_i) begin
                    value_d = '0;
                end else if (enable_i) begin
                    if (value_q == SEQ_MAX) begin
                        state_d = StIdle;
                        value_d = '0;
                        strb_d  = 1'b1;
                    end else begin
                        value_d = value_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        value_o = value_q;
        busy_o  = (state_q == StRun);
        strb_o  = strb_q;
    end

endmodule

// File: rtl/sdc_counter_pair.sv
// SD-card data-path counter pair: free-running word counter plus one-shot sequence counter,
// both released from reset through a two-flop synchroniser.
module sdc_counter_pair
    import sdc_cnt_pkg::*;
#(
    parameter int unsigned       CNT_DW  = WordCntDw,
    parameter logic [CNT_DW-1:0] CNT_MAX = WordCntMax,
    parameter int unsigned       SEQ_DW  = WordBitsDw,
    parameter logic [SEQ_DW-1:0] SEQ_MAX = WordBitsMax
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cnt_enable,
    output logic [CNT_DW-1:0] cnt_value,
    output logic              cnt_strb,
    input  logic              seq_enable,
    input  logic              seq_start_strb,
    output logic [SEQ_DW-1:0] seq_value,
    output logic              seq_busy,
    output logic              seq_strb
);

    localparam logic [CNT_DW-1:0] CntLast = CNT_MAX - 1'b1;

    // Assertion is immediate; release reaches the logic two clocks after reset rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [CNT_DW-1:0] cnt_value_q, cnt_value_d;
    logic              cnt_strb_q, cnt_strb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_value_q <= '0;
            cnt_strb_q  <= 1'b0;
        end else begin
            cnt_value_q <= cnt_value_d;
            cnt_strb_q  <= cnt_strb_d;
        end
    end

    always_comb begin
        cnt_value_d = cnt_value_q;
        cnt_strb_d  = 1'b0;
        if (cnt_enable) begin
            if (cnt_value_q == CntLast) begin
                cnt_value_d = '0;
                cnt_strb_d  = 1'b1;
            end else begin
                cnt_value_d = cnt_value_q + 1'b1;
            end
        end
    end

    assign cnt_value = cnt_value_q;
    assign cnt_strb  = cnt_strb_q;

    counter_seq #(
        .SEQ_DW  (SEQ_DW),
        .SEQ_MAX (SEQ_MAX)
    ) u_counter_seq (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (seq_enable),
        .start_strb_i (seq_start_strb),
        .value_o      (seq_value),
        .busy_o       (seq_busy),
        .strb_o       (seq_strb)
    );

endmodule

// File: tb/tb_sdc_counter_pair.sv
// Directed bench for sdc_counter_pair: reset, event counter, one-shot sequence,
// restart/pause, chaining and asynchronous mid-run reset.
module tb_sdc_counter_pair;

    localparam int CntMax = 64;
    localparam int SeqMax = 63;

    logic       clk;
    logic       reset;
    logic       cnt_enable;
    logic [7:0] cnt_value;
    logic       cnt_strb;
    logic       seq_enable;
    logic       seq_start_drv;
    logic       chain_en;
    logic       seq_start_strb;
    logic [5:0] seq_value;
    logic       seq_busy;
    logic       seq_strb;
    logic [31:0] all_out;

    int n_checks;
    int n_fail;
    int cyc, bc, n, last, k, busy_run, extra;

    assign seq_start_strb = seq_start_drv | (chain_en & seq_strb);
    assign all_out = {15'b0, cnt_value, cnt_strb, seq_value, seq_busy, seq_strb};

    sdc_counter_pair #(
        .CNT_DW  (8),
        .CNT_MAX (8'h40),
        .SEQ_DW  (6),
        .SEQ_MAX (6'h3F)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cnt_enable     (cnt_enable),
        .cnt_value      (cnt_value),
        .cnt_strb       (cnt_strb),
        .seq_enable     (seq_enable),
        .seq_start_strb (seq_start_strb),
        .seq_value      (seq_value),
        .seq_busy       (seq_busy),
        .seq_strb       (seq_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic start_pulse();
        seq_start_drv = 1'b1;
        @(negedge clk);
        seq_start_drv = 1'b0;
    endtask

    task automatic run_until_strb(input int limit, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (seq_strb !== 1'b1 && cycles < limit) begin
            if (seq_busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        cnt_enable    = 1'b0;
        seq_enable    = 1'b0;
        seq_start_drv = 1'b0;
        chain_en      = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cnt_enable    = i[0];
            seq_enable    = ~i[0];
            seq_start_drv = i[0];
            check_value("reset_hold_outputs", all_out, 32'h0);
        end
        @(negedge clk);
        cnt_enable    = 1'b0;
        seq_enable    = 1'b0;
        seq_start_drv = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("reset_release_idle", all_out, 32'h0);
        end
        seq_enable = 1'b1;
        @(negedge clk);
        check_value("seq_idle_ignores_enable", all_out, 32'h0);

        // Event counter: single pulses spaced three cycles apart
        extra = 0;
        for (int i = 0; i < CntMax; i++) begin
            cnt_enable = 1'b1;
            @(negedge clk);
            cnt_enable = 1'b0;
            check_value("cnt_step_value", cnt_value, (i + 1) % CntMax);
            check_value("cnt_step_strb", cnt_strb, (i == CntMax - 1));
            @(negedge clk);
            if (cnt_strb) extra++;
            @(negedge clk);
        end
        check_value("cnt_strb_single_cycle", extra, 0);

        // Event counter: continuous enables
        n    = 0;
        last = 0;
        cnt_enable = 1'b1;
        for (int i = 1; i <= 2 * CntMax; i++) begin
            @(negedge clk);
            if (cnt_strb) begin
                if (n > 0) check_value("cnt_strb_spacing", i - last, CntMax);
                last = i;
                n++;
            end
        end
        cnt_enable = 1'b0;
        check_value("cnt_continuous_strobes", n, 2);
        check_value("cnt_continuous_wrap", cnt_value, 0);

        // Sequence counter: single run
        start_pulse();
        check_value("seq_start_busy", seq_busy, 1);
        check_value("seq_start_value", seq_value, 0);
        run_until_strb(200, cyc, bc);
        check_value("seq_strb_latency", cyc, SeqMax + 1);
        check_value("seq_busy_cycles", bc, SeqMax + 1);
        check_value("seq_strb_busy_fall", {seq_strb, seq_busy}, 2'b10);
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (seq_strb) extra++;
        end
        check_value("seq_no_extra_strb", extra, 0);
        check_value("seq_idle_value", seq_value, 0);

        // Restart at seq_value == 10
        start_pulse();
        repeat (10) @(negedge clk);
        check_value("restart_pre_value", seq_value, 10);
        start_pulse();
        check_value("restart_value_busy_strb", {seq_value, seq_busy, seq_strb}, {6'd0, 2'b10});
        run_until_strb(200, cyc, bc);
        check_value("restart_strb_latency", cyc, SeqMax + 1);

        // Pause seq_enable for 5 cycles mid-run
        @(negedge clk);
        start_pulse();
        repeat (20) @(negedge clk);
        check_value("pause_pre_value", seq_value, 20);
        seq_enable = 1'b0;
        repeat (5) @(negedge clk);
        check_value("pause_hold_value", seq_value, 20);
        seq_enable = 1'b1;
        run_until_strb(200, cyc, bc);
        check_value("pause_strb_latency", cyc + 25, SeqMax + 1 + 5);

        // Chaining: strobe fed back as start; each run has SeqMax+1 busy cycles
        // and the strobe cycle itself sits between runs.
        @(negedge clk);
        chain_en = 1'b1;
        start_pulse();
        n        = 0;
        last     = 0;
        k        = 0;
        busy_run = 0;
        while (n < 3 && k < 400) begin
            if (seq_strb) begin
                check_value("chain_strb_gap", k - last, (n == 0) ? SeqMax + 1 : SeqMax + 2);
                check_value("chain_busy_run", busy_run, SeqMax + 1);
                last     = k;
                busy_run = 0;
                n++;
                if (n == 3) chain_en = 1'b0;
            end else if (seq_busy) begin
                busy_run++;
            end
            if (n < 3) begin
                @(negedge clk);
                k++;
            end
        end
        check_value("chain_strobe_count", n, 3);
        @(negedge clk);
        check_value("chain_stopped", {seq_busy, seq_strb}, 2'b00);

        // Asynchronous reset mid-run
        start_pulse();
        cnt_enable = 1'b1;
        repeat (10) @(negedge clk);
        cnt_enable = 1'b0;
        check_value("areset_pre_cnt", cnt_value, 10);
        check_value("areset_pre_seq", {seq_value, seq_busy}, {6'd10, 1'b1});
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_value("areset_clears_now", all_out, 32'h0);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (seq_strb || cnt_strb) extra++;
        end
        reset = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (seq_strb || cnt_strb) extra++;
        end
        check_value("areset_no_strb", extra, 0);
        check_value("areset_idle_after", all_out, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
